mag_cmp_seq: RTL and testbench
==============================

# mag_cmp_seq

Parametrised sequential magnitude comparator. It compares two W-bit operands MSB-first, CHUNK bits per clock, under a start/ready/done handshake. It produces registered gt/eq/lt flags and supports optional two's-complement ordering. It is the multi-cycle, width-generic successor to the fixed-width combinational greater-than comparators, for datapaths where a full-width compare does not close timing in one cycle.

## Interface
- W, 16, operand width in bits; must be a multiple of CHUNK
- CHUNK, 2, bits compared per cycle; 1 ≤ CHUNK ≤ W
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a compare; sampled only when ready=1
- a  in  W  operand A; sampled with start
- b  in  W  operand B; sampled with start
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with start
- ready  out  1  block is idle and accepts start
- done  out  1  one-cycle pulse: the result flags are newly valid
- gt  out  1  A > B
- eq  out  1  A == B
- lt  out  1  A < B

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE: ready=1.
  - With start=1, latch a and b into shift registers and latch signed_mode.
  - In signed mode, invert the MSB of both latched operands, so that an unsigned compare gives the signed ordering.
  - Load the chunk counter with W/CHUNK, clear the decision flags, and go to RUN.
- RUN: each cycle, compare the top CHUNK bits of both shift registers with the cmp_chunk sub-module.
  - If the chunks differ and no decision exists yet, record gt or lt.
  - Shift both registers left by CHUNK and decrement the counter.
  - With early exit enabled, the first differing chunk moves the FSM to DONE.
  - Otherwise the FSM moves to DONE when the counter reaches its final chunk. If no chunk differed, eq is set.
- DONE: done=1 for exactly this cycle. Go to IDLE on the next edge.
- start while ready=0 is ignored and not queued.
- Exactly one of gt/eq/lt is 1 after any completed compare. The flags hold their value until the next result is registered.
- Reset, including mid-RUN: state goes to IDLE, and ready=1, done=0, gt=eq=lt=0. The aborted compare produces no done.

## Timing
- Reset values: ready=1, done=0, gt=0, eq=0, lt=0.
- Let start be sampled at edge E0, and let k be the 1-based index of the deciding chunk. k = W/CHUNK for equal operands, or when early exit is disabled.
  - The result is registered at edge Ek.
  - done=1 and the flags are valid during the cycle after Ek.
  - ready returns to 1 after edge Ek+1.
- Maximum throughput is one compare per W/CHUNK+2 cycles.
- Result flags and done change together, on the same edge.

## Configuration
- MAG_CMP_EARLY_EXIT_EN defined: the compare terminates at the first differing chunk, giving variable latency of 1..W/CHUNK cycles.
- MAG_CMP_EARLY_EXIT_EN not defined: the compare always runs W/CHUNK RUN cycles (constant latency). The first difference is still the one recorded, and later chunks never override it.

## Structure
- Package mag_cmp_pkg contains:
  - the state enum typedef state_t {IDLE, RUN, DONE}
  - the result encoding typedef
  - a function that computes the counter width from W and CHUNK
- Sub-module cmp_chunk is a combinational CHUNK-bit compare producing gt and eq. It is instantiated once, on the top CHUNK bits of the shift registers.
- Elaboration asserts that W % CHUNK == 0.

## Test plan
All scenarios use W=8, CHUNK=2, with MAG_CMP_EARLY_EXIT_EN defined except where noted.
- Unsigned, a=0xA5, b=0x3C: done one cycle after E1 (k=1), gt=1, eq=0, lt=0.
- a=b=0x5A: k=4, eq=1; done pulses for exactly one cycle; flags hold until the next start.
- a=0x58, b=0x5C: decided at chunk 3 (10 vs 11), k=3, lt=1.
- a=0x80, b=0x01: with signed_mode=1, lt=1; with signed_mode=0, gt=1.
- Two boundary cases:
  - start pulsed during RUN is ignored, and the first result is unchanged.
  - reset asserted mid-RUN: ready=1 and the flags read 0 immediately; no done follows.
- Macro undefined, a=0xA5, b=0x3C: k=4 (done after E4), gt=1 preserved despite later chunks.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package mag_cmp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic gt;
      logic eq;
      logic lt;
   } result_t;

   localparam result_t RESULT_CLEAR = '0;

   // Counter must hold W/CHUNK itself, not just W/CHUNK-1.
   function automatic int cnt_width(input int w, input int chunk);
      return $clog2(w / chunk + 1);
   endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             gt,
   output logic             eq
);

   assign gt = (a > b);
   assign eq = (a == b);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per clock.
// Define MAG_CMP_EARLY_EXIT_EN to stop at the first differing chunk.
//
// state | meaning
// IDLE  | ready, waiting for start
// RUN   | comparing one chunk per cycle
// DONE  | result flags newly valid, done pulse
module mag_cmp_seq
   import mag_cmp_pkg::*;
#(
   parameter int W     = 16,
   parameter int CHUNK = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         signed_mode,
   output logic         ready,
   output logic         done,
   output logic         gt,
   output logic         eq,
   output logic         lt
);

   localparam int NCH   = W / CHUNK;
   localparam int CNT_W = cnt_width(W, CHUNK);

   if ((CHUNK < 1) || (CHUNK > W) || ((W % CHUNK) != 0)) begin : g_bad_cfg
      $error("mag_cmp_seq: W must be a positive multiple of CHUNK");
   end

   state_t           state;
   state_t           state_nxt;
   logic [W-1:0]     sh_a;
   logic [W-1:0]     sh_b;
   logic [W-1:0]     msb_flip;
   logic [CNT_W-1:0] cnt;
   logic             dec_gt;
   logic             dec_lt;
   result_t          res;
   logic             c_gt;
   logic             c_eq;
   logic             first_diff;
   logic             nxt_gt;
   logic             nxt_lt;
   logic             last_chunk;
   logic             finish;
   logic             accept;

   cmp_chunk #(.CHUNK(CHUNK)) u_cmp (
      .a  (sh_a[W-1 -: CHUNK]),
      .b  (sh_b[W-1 -: CHUNK]),
      .gt (c_gt),
      .eq (c_eq)
   );

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign msb_flip   = W'(signed_mode) << (W - 1);
   assign first_diff = !c_eq && !(dec_gt || dec_lt);
   assign nxt_gt     = dec_gt || (first_diff && c_gt);
   assign nxt_lt     = dec_lt || (first_diff && !c_gt);
   assign last_chunk = (cnt == CNT_W'(1));

`ifdef MAG_CMP_EARLY_EXIT_EN
   assign finish = last_chunk || first_diff;
`else
   assign finish = last_chunk;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               accept    = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (finish) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh_a   <= '0;
         sh_b   <= '0;
         cnt    <= '0;
         dec_gt <= 1'b0;
         dec_lt <= 1'b0;
         res    <= RESULT_CLEAR;
      end else if (accept) begin
         sh_a   <= a ^ msb_flip;
         sh_b   <= b ^ msb_flip;
         cnt    <= CNT_W'(NCH);
         dec_gt <= 1'b0;
         dec_lt <= 1'b0;
      end else if (state == RUN) begin
         sh_a   <= sh_a << CHUNK;
         sh_b   <= sh_b << CHUNK;
         cnt    <= cnt - CNT_W'(1);
         dec_gt <= nxt_gt;
         dec_lt <= nxt_lt;
         if (finish) begin
            res <= '{gt: nxt_gt, eq: !(nxt_gt || nxt_lt), lt: nxt_lt};
         end
      end
   end

   assign gt = res.gt;
   assign eq = res.eq;
   assign lt = res.lt;

endmodule

// File: tb/tb_mag_cmp_seq.sv
// Randomised and directed bench for mag_cmp_seq at W=8, CHUNK=2.
module tb_mag_cmp_seq;

   localparam int W     = 8;
   localparam int CHUNK = 2;
   localparam int NCH   = W / CHUNK;

   logic         clk         = 1'b0;
   logic         reset       = 1'b1;
   logic         start       = 1'b0;
   logic         signed_mode = 1'b0;
   logic [W-1:0] a           = '0;
   logic [W-1:0] b           = '0;
   logic         ready;
   logic         done;
   logic         gt;
   logic         eq;
   logic         lt;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   mag_cmp_seq #(.W(W), .CHUNK(CHUNK)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .ready       (ready),
      .done        (done),
      .gt          (gt),
      .eq          (eq),
      .lt          (lt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ordering straight from integer arithmetic: {gt, eq, lt}.
   function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic sm);
      int xv;
      int yv;
      if (sm) begin
         xv = int'($signed(x));
         yv = int'($signed(y));
      end else begin
         xv = int'({1'b0, x});
         yv = int'({1'b0, y});
      end
      return {xv > yv, xv == yv, xv < yv};
   endfunction

   // Deciding chunk = chunk holding the highest differing bit.
   function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      int           msb;
      d = x ^ y;
      if (d == '0) return NCH;
`ifdef MAG_CMP_EARLY_EXIT_EN
      msb = 0;
      for (int i = 0; i < W; i++) if (d[i]) msb = i;
      return (W - 1 - msb) / CHUNK + 1;
`else
      msb = 0;
      return NCH + msb;
`endif
   endfunction

   task automatic do_cmp(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                         input bit poke, input string tag);
      logic [2:0] ef;
      int         ek;
      int         n;
      ef = ref_flags(x, y, sm);
      ek = ref_latency(x, y);
      @(negedge clk);
      a = x; b = y; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~x; b = ~y; signed_mode = ~sm;
      check_eq({tag, " busy"}, {31'b0, ready}, 32'd0);
      n = 0;
      while (!done && n < 3 * NCH) begin
         start = poke && (n == 0);
         if (poke && n == 0) begin
            a = y; b = x;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check_eq({tag, " latency"}, n, ek);
      check_eq({tag, " flags"}, {29'b0, gt, eq, lt}, {29'b0, ef});
      @(negedge clk);
      check_eq({tag, " done pulse"}, {30'b0, done, ready}, 32'd1);
      check_eq({tag, " flags held"}, {29'b0, gt, eq, lt}, {29'b0, ef});
      @(negedge clk);
      check_eq({tag, " idle"}, {30'b0, done, ready}, 32'd1);
   endtask

   task automatic reset_mid_run();
      int seen;
      @(negedge clk);
      a = 8'h5A; b = 8'h5A; signed_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check_eq("rst mid ready", {31'b0, ready}, 32'd1);
      check_eq("rst mid outs", {28'b0, done, gt, eq, lt}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 2 * NCH; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check_eq("rst mid no done", seen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      @(negedge clk);
      @(negedge clk);
      check_eq("reset ready", {31'b0, ready}, 32'd1);
      check_eq("reset outs", {28'b0, done, gt, eq, lt}, 32'd0);
      reset = 1'b0;

      do_cmp(8'hA5, 8'h3C, 1'b0, 1'b0, "a5_3c");
      do_cmp(8'h5A, 8'h5A, 1'b0, 1'b0, "equal");
      do_cmp(8'h58, 8'h5C, 1'b0, 1'b0, "58_5c");
      do_cmp(8'h80, 8'h01, 1'b1, 1'b0, "signed");
      do_cmp(8'h80, 8'h01, 1'b0, 1'b0, "unsigned");
      do_cmp(8'h5A, 8'h5A, 1'b0, 1'b1, "poke eq");
      do_cmp(8'h58, 8'h5C, 1'b0, 1'b1, "poke lt");
      do_cmp(8'hFF, 8'h00, 1'b1, 1'b0, "neg one");

      for (int i = 0; i < 40; i++) begin
         rx = W'($urandom);
         ry = ($urandom_range(0, 3) == 0) ? rx : W'($urandom);
         do_cmp(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
      end

      reset_mid_run();
      do_cmp(8'h3C, 8'hA5, 1'b0, 1'b0, "after reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
